// File: rtl/tune_seq_pkg.sv
// Shared definitions for the tune sequencer: FSM state encoding, special pitch
// codes, ROM word field positions and the pitch-to-period table.
package tune_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StPlay,
      StGap,
      StEnd
   } state_e;

   localparam logic [3:0] PITCH_REST = 4'd0;
   localparam logic [3:0] PITCH_END  = 4'd15;

   // ROM word layout: {pitch[3:0], dur[3:0]}
   localparam int unsigned PITCH_MSB = 7;
   localparam int unsigned PITCH_LSB = 4;
   localparam int unsigned DUR_MSB   = 3;
   localparam int unsigned DUR_LSB   = 0;

   localparam int unsigned PERIOD_W = 12;

   // Half-period counts for pitches 1..14; rest and end marker map to 0.
   function automatic logic [PERIOD_W-1:0] period_of(input logic [3:0] pitch);
      logic [PERIOD_W-1:0] p;
      case (pitch)
         4'd1:    p = 12'd1911;
         4'd2:    p = 12'd1804;
         4'd3:    p = 12'd1703;
         4'd4:    p = 12'd1607;
         4'd5:    p = 12'd1517;
         4'd6:    p = 12'd1432;
         4'd7:    p = 12'd1351;
         4'd8:    p = 12'd1276;
         4'd9:    p = 12'd1204;
         4'd10:   p = 12'd1136;
         4'd11:   p = 12'd1073;
         4'd12:   p = 12'd1012;
         4'd13:   p = 12'd956;
         4'd14:   p = 12'd902;
         default: p = '0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/tune_rom.sv
// Synchronous 64x8 melody ROM, one-cycle read latency.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset (clears the output register)
//   addr  in  {song[1:0], note_idx[3:0]}
//   data  out registered ROM word {pitch, dur}
// Unlisted locations hold the end marker.
module tune_rom (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] addr,
   output logic [7:0] data
);

   logic [7:0] word;

   always_comb begin
      word = 8'hF0;
      case (addr)
         // song 0
         6'd0:    word = 8'h13;
         // song 1
         6'd16:   word = 8'h00;
         6'd17:   word = 8'h21;
         // song 2: 16 one-beat notes, no end marker
         6'd32:   word = 8'h10;
         6'd33:   word = 8'h20;
         6'd34:   word = 8'h30;
         6'd35:   word = 8'h40;
         6'd36:   word = 8'h50;
         6'd37:   word = 8'h60;
         6'd38:   word = 8'h70;
         6'd39:   word = 8'h80;
         6'd40:   word = 8'h90;
         6'd41:   word = 8'hA0;
         6'd42:   word = 8'hB0;
         6'd43:   word = 8'hC0;
         6'd44:   word = 8'hD0;
         6'd45:   word = 8'hE0;
         6'd46:   word = 8'h10;
         6'd47:   word = 8'h20;
         // song 3
         6'd48:   word = 8'h35;
         6'd49:   word = 8'h47;
         default: word = 8'hF0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else begin
         data <= word;
      end
   end

endmodule

// File: rtl/tune_sequencer.sv
// Melody sequencer: steps through the note ROM and drives a tone generator.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   song_sel     in   song number, sampled when start is accepted
//   start        in   level, accepted in idle only
//   stop         in   level, aborts playback (highest priority)
//   tone_period  out  half-period count for the tone generator, 0 when silent
//   tone_en      out  tone generator gate
//   busy         out  high whenever not idle
//   note_idx     out  index of the current note
//   done         out  one-cycle pulse when a song ends naturally
// Build option: define TUNE_SEQ_LOOP_EN to repeat the song forever (no done).
module tune_sequencer
   import tune_seq_pkg::*;
#(
   parameter int unsigned MAX_COUNT = 100,
   parameter int unsigned PW        = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    song_sel,
   input  logic          start,
   input  logic          stop,
   output logic [PW-1:0] tone_period,
   output logic          tone_en,
   output logic          busy,
   output logic [3:0]    note_idx,
   output logic          done
);

   localparam int unsigned CW = $clog2(MAX_COUNT);

   state_e        state_q, state_d;
   logic [1:0]    song_q, song_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    beats_q, beats_d;
   logic [3:0]    pitch_q, pitch_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_clr;
   logic          tick;
   logic [7:0]    rom_data;
   logic [3:0]    rom_pitch;
   logic [3:0]    rom_dur;
   logic          play;
   logic          tone_en_d;
   logic [PW-1:0] tone_period_d;

   // Addressed from next-state values so the word is ready during the FETCH cycle.
   tune_rom u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr ({song_d, idx_d}),
      .data (rom_data)
   );

   assign rom_pitch = rom_data[PITCH_MSB:PITCH_LSB];
   assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
   assign tick      = (cnt_q == CW'(MAX_COUNT - 1));

   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      idx_d   = idx_q;
      beats_d = beats_q;
      pitch_d = pitch_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
               song_d  = song_sel;
               idx_d   = 4'd0;
            end
         end
         StFetch: begin
            if (rom_pitch == PITCH_END) begin
               state_d = StEnd;
            end else begin
               state_d = StPlay;
               pitch_d = rom_pitch;
               beats_d = rom_dur;
               cnt_clr = 1'b1;
            end
         end
         StPlay: begin
            if (tick) begin
               if (beats_q == 4'd0) begin
                  state_d = StGap;
                  cnt_clr = 1'b1;
               end else begin
                  beats_d = beats_q - 4'd1;
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (idx_q == 4'd15) begin
                  state_d = StEnd;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StFetch;
               end
            end
         end
         StEnd: begin
            idx_d = 4'd0;
`ifdef TUNE_SEQ_LOOP_EN
            state_d = StFetch;
`else
            state_d = StIdle;
`endif
         end
         default: state_d = StIdle;
      endcase
      if (stop) begin
         state_d = StIdle;
         idx_d   = 4'd0;
      end
   end

   assign cnt_d = (cnt_clr || tick) ? '0 : cnt_q + CW'(1);

   // Tone outputs are registered; stop silences them on the very next edge.
   assign play          = (state_q == StPlay) && !stop;
   assign tone_en_d     = play && (pitch_q != PITCH_REST);
   assign tone_period_d = play ? PW'(period_of(pitch_q)) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         song_q      <= '0;
         idx_q       <= '0;
         beats_q     <= '0;
         pitch_q     <= '0;
         cnt_q       <= '0;
         tone_en     <= 1'b0;
         tone_period <= '0;
      end else begin
         state_q     <= state_d;
         song_q      <= song_d;
         idx_q       <= idx_d;
         beats_q     <= beats_d;
         pitch_q     <= pitch_d;
         cnt_q       <= cnt_d;
         tone_en     <= tone_en_d;
         tone_period <= tone_period_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign note_idx = idx_q;
`ifdef TUNE_SEQ_LOOP_EN
   assign done = 1'b0;
`else
   assign done = (state_q == StEnd);
`endif

endmodule
